regfile_wb_ctrl: RTL and testbench

Write-back controller for the 32x32 register file: shares its single write port between the execute (ALU) and load/store result streams with round-robin arbitration, and keeps a pending-write scoreboard that raises a hazard flag to stall issue. Sits between the EX/LSU stages and `regfile`. Drives `we0/wr_addr0/wr_din0` through a registered stage. Optionally forwards the in-flight write to the read data seen by decode.

---
 rtl/regfile_wb_ctrl.sv | 115 +++++++++++
 tb/tb_regfile_wb_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the 32x32 register file.
// Shares the single regfile write port between the execute and load/store result
// streams (round-robin on conflict), registers the write, and tracks pending
// destination registers in a scoreboard that raises `hazard` to stall issue.
// Optional feature macro: WB_BYPASS_EN forwards the in-flight write to the decode
// operands and lets a reader of the committing register issue without stalling.
module regfile_wb_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic             hazard,
  input  logic             exe_valid,
  input  logic [AW-1:0]    exe_addr,
  input  logic [WIDTH-1:0] exe_data,
  output logic             exe_ready,
  input  logic             lsu_valid,
  input  logic [AW-1:0]    lsu_addr,
  input  logic [WIDTH-1:0] lsu_data,
  output logic             lsu_ready,
  output logic             rf_we,
  output logic [AW-1:0]    rf_addr,
  output logic [WIDTH-1:0] rf_din,
  input  logic [WIDTH-1:0] rf_rdata0,
  input  logic [WIDTH-1:0] rf_rdata1,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data
);

  typedef enum logic {GrantExe = 1'b0, GrantLsu = 1'b1} grant_e;

  grant_e           last_grant_q;
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_eff;

  // Round-robin grant: on conflict the requester not granted last wins.
  always_comb begin
    exe_ready = 1'b0;
    lsu_ready = 1'b0;
    if (rst) begin
      if (exe_valid && lsu_valid) begin
        if (last_grant_q == GrantExe) lsu_ready = 1'b1;
        else                          exe_ready = 1'b1;
      end else begin
        exe_ready = exe_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  // Registered write stage; an accepted write to x0 is consumed but never enabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we        <= 1'b0;
      rf_addr      <= '0;
      rf_din       <= '0;
      last_grant_q <= GrantExe;
    end else if (exe_ready) begin
      rf_we        <= (exe_addr != '0);
      rf_addr      <= exe_addr;
      rf_din       <= exe_data;
      last_grant_q <= GrantExe;
    end else if (lsu_ready) begin
      rf_we        <= (lsu_addr != '0);
      rf_addr      <= lsu_addr;
      rf_din       <= lsu_data;
      last_grant_q <= GrantLsu;
    end else begin
      rf_we        <= 1'b0;
    end
  end

  // Busy view used for stall decisions; with bypass the committing register is free.
  always_comb begin
    busy_eff = busy_q;
`ifdef WB_BYPASS_EN
    if (rf_we) busy_eff[rf_addr] = 1'b0;
`endif
  end

  // Stall on RAW (either source) or WAW (destination) against a pending write.
  assign hazard = iss_valid && rst &&
                  (busy_eff[rs1_addr] | busy_eff[rs2_addr] | busy_eff[iss_rd]);

  // Operand selection for decode.
`ifdef WB_BYPASS_EN
  assign rs1_data = (rf_we && rf_addr == rs1_addr && rs1_addr != '0) ? rf_din : rf_rdata0;
  assign rs2_data = (rf_we && rf_addr == rs2_addr && rs2_addr != '0) ? rf_din : rf_rdata1;
`else
  assign rs1_data = rf_rdata0;
  assign rs2_data = rf_rdata1;
`endif

  // Scoreboard next state: clear on commit, then set on issue so set wins a collision.
  always_comb begin
    busy_d = busy_q;
    if (rf_we) busy_d[rf_addr] = 1'b0;
    if (iss_valid && !hazard && iss_rd != '0) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard state; pending entries are dropped on reset.
  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl. Inputs change on the falling
// edge; outputs are compared on the falling edge (registered) or 1 time unit after
// an input change (combinational).
module tb_regfile_wb_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam logic [WIDTH-1:0] RD0 = 32'h1111_1111;
  localparam logic [WIDTH-1:0] RD1 = 32'h2222_2222;

  logic             clk;
  logic             rst;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd, rs1_addr, rs2_addr;
  logic             hazard;
  logic             exe_valid, exe_ready;
  logic [AW-1:0]    exe_addr;
  logic [WIDTH-1:0] exe_data;
  logic             lsu_valid, lsu_ready;
  logic [AW-1:0]    lsu_addr;
  logic [WIDTH-1:0] lsu_data;
  logic             rf_we;
  logic [AW-1:0]    rf_addr;
  logic [WIDTH-1:0] rf_din;
  logic [WIDTH-1:0] rf_rdata0, rf_rdata1;
  logic [WIDTH-1:0] rs1_data, rs2_data;

  int n_cmp;
  int n_fail;

  regfile_wb_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .hazard    (hazard),
    .exe_valid (exe_valid),
    .exe_addr  (exe_addr),
    .exe_data  (exe_data),
    .exe_ready (exe_ready),
    .lsu_valid (lsu_valid),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_din    (rf_din),
    .rf_rdata0 (rf_rdata0),
    .rf_rdata1 (rf_rdata1),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
    exe_valid = 1'b0; exe_addr = '0; exe_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    exe_valid = 1'b1; exe_addr = 5'd4; exe_data = 32'h1;
    lsu_valid = 1'b1; lsu_addr = 5'd6; lsu_data = 32'h2;
    iss_valid = 1'b1; iss_rd = 5'd1; rs1_addr = 5'd2; rs2_addr = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    n_cmp++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_addr: got %0d want 0", rf_addr); end
    n_cmp++; if (rf_din !== 32'h0) begin n_fail++; $display("FAIL reset_rf_din: got %h want 0", rf_din); end
    n_cmp++; if (exe_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got exe=%b lsu=%b want 0 0", exe_ready, lsu_ready); end
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    // Release and accept a single execute write.
    rst = 1'b1;
    idle_inputs();
    exe_valid = 1'b1; exe_addr = 5'd5; exe_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (exe_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      n_fail++; $display("FAIL first_grant: got exe=%b lsu=%b want 1 0", exe_ready, lsu_ready); end
    @(negedge clk);
    exe_valid = 1'b0;
    n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_din !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL first_write: got we=%b addr=%0d din=%h want 1 5 deadbeef",
                         rf_we, rf_addr, rf_din); end
    @(negedge clk);
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %b want 0", rf_we); end
  endtask

  task automatic test_arbitration();
    logic       exp_lsu [4];
    logic [4:0] exp_addr [4];
    exp_lsu[0] = 1'b1; exp_lsu[1] = 1'b0; exp_lsu[2] = 1'b1; exp_lsu[3] = 1'b0;
    exp_addr[0] = 5'd20; exp_addr[1] = 5'd10; exp_addr[2] = 5'd20; exp_addr[3] = 5'd10;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    exe_valid = 1'b1; exe_addr = 5'd10;
    lsu_valid = 1'b1; lsu_addr = 5'd20;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== exp_addr[i-1]) begin
          n_fail++; $display("FAIL arb_rf_addr[%0d]: got we=%b addr=%0d want 1 %0d",
                             i - 1, rf_we, rf_addr, exp_addr[i-1]); end
      end
      exe_data = 32'h100 + i; lsu_data = 32'h200 + i;
      #1;
      n_cmp++; if (lsu_ready !== exp_lsu[i] || exe_ready !== !exp_lsu[i]) begin
        n_fail++; $display("FAIL arb_grant[%0d]: got exe=%b lsu=%b want exe=%b lsu=%b",
                           i, exe_ready, lsu_ready, !exp_lsu[i], exp_lsu[i]); end
    end
    @(negedge clk);
    idle_inputs();
    n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd10 || rf_din !== 32'h103) begin
      n_fail++; $display("FAIL arb_last: got we=%b addr=%0d din=%h want 1 10 00000103",
                         rf_we, rf_addr, rf_din); end
  endtask

  task automatic test_x0_write();
    @(negedge clk);
    idle_inputs();
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h1234;
    #1;
    n_cmp++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", lsu_ready); end
    @(negedge clk);
    idle_inputs();
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %b want 0", rf_we); end
    iss_valid = 1'b1; iss_rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got hazard=%b want 0", hazard); end
  endtask

  task automatic test_raw();
    @(negedge clk);
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd7; rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1;
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL raw_issue: got hazard=%b want 0", hazard); end
    @(negedge clk);
    iss_rd = 5'd0; rs1_addr = 5'd7; rs2_addr = 5'd0;
    exe_valid = 1'b1; exe_addr = 5'd7; exe_data = 32'hA5;
    #1;
    n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got hazard=%b want 1", hazard); end
    n_cmp++; if (exe_ready !== 1'b1) begin n_fail++; $display("FAIL raw_exe_ready: got %b want 1", exe_ready); end
    @(negedge clk);
    exe_valid = 1'b0;
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd7) begin
      n_fail++; $display("FAIL raw_commit: got we=%b addr=%0d want 1 7", rf_we, rf_addr); end
`ifdef WB_BYPASS_EN
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL raw_bypass_hazard: got %b want 0", hazard); end
    n_cmp++; if (rs1_data !== 32'hA5) begin n_fail++; $display("FAIL raw_bypass_rs1: got %h want 000000a5", rs1_data); end
`else
    n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL raw_commit_hazard: got %b want 1", hazard); end
    n_cmp++; if (rs1_data !== RD0) begin n_fail++; $display("FAIL raw_rs1: got %h want %h", rs1_data, RD0); end
`endif
    n_cmp++; if (rs2_data !== RD1) begin n_fail++; $display("FAIL raw_rs2: got %h want %h", rs2_data, RD1); end
    @(negedge clk);
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL raw_release: got hazard=%b want 0", hazard); end
    n_cmp++; if (rs1_data !== RD0) begin n_fail++; $display("FAIL raw_rs1_after: got %h want %h", rs1_data, RD0); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    idle_inputs();
    exe_valid = 1'b1; exe_addr = 5'd3; exe_data = 32'h33;
    @(negedge clk);
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd3; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd3) begin
      n_fail++; $display("FAIL coll_commit: got we=%b addr=%0d want 1 3", rf_we, rf_addr); end
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL coll_issue: got hazard=%b want 0", hazard); end
    @(negedge clk);
    iss_rd = 5'd0; rs1_addr = 5'd3;
    #1;
    n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL coll_set_wins: got hazard=%b want 1", hazard); end
    // Retire r3 through the load path so later scenarios start clean.
    lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'h3;
    @(negedge clk);
    lsu_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL coll_cleared: got hazard=%b want 0", hazard); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd12;
    exe_valid = 1'b1; exe_addr = 5'd9; exe_data = 32'h55;
    #1;
    n_cmp++; if (exe_ready !== 1'b1 || hazard !== 1'b0) begin
      n_fail++; $display("FAIL mid_accept: got ready=%b hazard=%b want 1 0", exe_ready, hazard); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd9) begin
      n_fail++; $display("FAIL mid_held: got we=%b addr=%0d want 1 9", rf_we, rf_addr); end
    @(negedge clk);
    n_cmp++; if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_din !== 32'h0) begin
      n_fail++; $display("FAIL mid_discard: got we=%b addr=%0d din=%h want 0 0 0", rf_we, rf_addr, rf_din); end
    rst = 1'b1;
    iss_valid = 1'b1; iss_rd = 5'd12; rs1_addr = 5'd12; rs2_addr = 5'd9;
    #1;
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL mid_busy_lost: got hazard=%b want 0", hazard); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    rf_rdata0 = RD0;
    rf_rdata1 = RD1;
    idle_inputs();
    test_reset();
    test_arbitration();
    test_x0_write();
    test_raw();
    test_collision();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
